// File: rtl/kamus_pkg.sv
// Shared types and helpers for the kamus l1d bridge: access sizes, store-buffer
// entry layout, and byte-enable / lane-replication rules.
package kamus_pkg;

   localparam int unsigned KAMUS_AW = 32;
   localparam int unsigned KAMUS_DW = 32;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } l1d_size_e;

   typedef struct packed {
      logic [KAMUS_AW-1:0] addr;
      logic [3:0]          be;
      logic [KAMUS_DW-1:0] wdata;
   } sb_entry_t;

   // Size code 3 falls through to the word case everywhere below.
   function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] be;
      case (size)
         SZ_B:    be = 4'b0001 << offset;
         SZ_H:    be = 4'b0011 << {offset[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [KAMUS_DW-1:0] calc_wdata(input logic [1:0]          size,
                                                      input logic [KAMUS_DW-1:0] data);
      logic [KAMUS_DW-1:0] wdata;
      case (size)
         SZ_B:    wdata = {4{data[7:0]}};
         SZ_H:    wdata = {2{data[15:0]}};
         default: wdata = data;
      endcase
      return wdata;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic mis;
      case (size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = offset[0];
         default: mis = (offset != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/kamus_sync_fifo.sv
// Small synchronous in-order FIFO with registered occupancy. DEPTH must be a
// power of two so the pointers wrap naturally.
module kamus_sync_fifo #(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = logic [31:0]
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  entry_t                 push_data_i,
   input  logic                   pop_i,
   output entry_t                 head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   entry_t         mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q;
   logic [PW-1:0]  rd_ptr_q;
   logic [PW:0]    count_q;
   logic           do_push;
   logic           do_pop;

   // Full/empty come from the registered count, so a same-cycle pop never frees a slot.
   always_comb begin
      full_o  = (count_q == (PW+1)'(DEPTH));
      empty_o = (count_q == '0);
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      head_o  = mem_q[rd_ptr_q];
      count_o = count_q;
   end

   // Entry storage; contents need no reset because count gates every read.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/kamus_l1d_bridge.sv
// Data-side bridge from the kamus core l1d port to L1 data memory. Stores are
// posted into an in-order buffer and drained in the background; loads wait for
// the buffer to empty and then run as a single outstanding read.
module kamus_l1d_bridge
   import kamus_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   l1d_req_i,
   input  logic                   l1d_we_i,
   input  logic [1:0]             l1d_size_i,
   input  logic [AW-1:0]          l1d_addr_i,
   input  logic [DW-1:0]          l1d_wr_data_i,
   output logic                   l1d_gnt_o,
   output logic                   l1d_rvalid_o,
   output logic [DW-1:0]          l1d_rd_data_o,
   output logic                   l1d_err_o,
   output logic                   mem_req_o,
   output logic                   mem_we_o,
   output logic [AW-1:0]          mem_addr_o,
   output logic [3:0]             mem_be_o,
   output logic [DW-1:0]          mem_wdata_o,
   input  logic                   mem_gnt_i,
   input  logic                   mem_rvalid_i,
   input  logic [DW-1:0]          mem_rdata_i,
   output logic                   sb_empty_o,
   output logic [$clog2(DEPTH):0] sb_count_o
);

   typedef enum logic [0:0] {StIdle, StRdWait} state_e;

   state_e        state_q;
   logic          rvalid_q;
   logic [DW-1:0] rd_data_q;

   logic          misaligned;
   logic [AW-1:0] word_addr;
   logic          sb_push, sb_pop, sb_full, sb_empty;
   logic          rd_issue;
   sb_entry_t     push_entry, sb_head;

   assign misaligned = is_misaligned(l1d_size_i, l1d_addr_i[1:0]);
   assign word_addr  = {l1d_addr_i[AW-1:2], 2'b00};
   assign push_entry = '{addr:  KAMUS_AW'(word_addr),
                         be:    calc_be(l1d_size_i, l1d_addr_i[1:0]),
                         wdata: calc_wdata(l1d_size_i, l1d_wr_data_i)};

   kamus_sync_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (sb_entry_t)
   ) u_sb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (sb_push),
      .push_data_i (push_entry),
      .pop_i       (sb_pop),
      .head_o      (sb_head),
      .full_o      (sb_full),
      .empty_o     (sb_empty),
      .count_o     (sb_count_o)
   );

   assign sb_empty_o = sb_empty;

   // Grant, error, drain and read-issue muxing; nothing is offered while in reset or RdWait.
   always_comb begin
      l1d_gnt_o   = 1'b0;
      l1d_err_o   = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      sb_push     = 1'b0;
      sb_pop      = 1'b0;
      rd_issue    = 1'b0;
      if (!rst_i && state_q == StIdle) begin
         if (!sb_empty) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = AW'(sb_head.addr);
            mem_be_o    = sb_head.be;
            mem_wdata_o = sb_head.wdata;
            sb_pop      = mem_gnt_i;
         end
         if (l1d_req_i) begin
            if (misaligned) begin
               l1d_gnt_o = 1'b1;
               l1d_err_o = 1'b1;
            end else if (l1d_we_i) begin
               l1d_gnt_o = !sb_full;
               sb_push   = !sb_full;
            end else if (sb_empty) begin
               // Loads only go out once every earlier store has drained.
               mem_req_o  = 1'b1;
               mem_we_o   = 1'b0;
               mem_addr_o = word_addr;
               mem_be_o   = 4'b1111;
               l1d_gnt_o  = mem_gnt_i;
               rd_issue   = mem_gnt_i;
            end
         end
      end
   end

   // Read FSM with registered load-response outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         rvalid_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rvalid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (rd_issue) state_q <= StRdWait;
            end
            StRdWait: begin
               if (mem_rvalid_i) begin
                  rd_data_q <= mem_rdata_i;
                  rvalid_q  <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign l1d_rvalid_o  = rvalid_q;
   assign l1d_rd_data_o = rd_data_q;

endmodule
